// File: rtl/uart_tx_buffered_pkg.sv
// Shared types for the buffered UART transmitter: frame states and data-width bounds.
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side push handshake between the bus wrapper (master) and the transmitter (slave).
interface uart_tx_buffered_if #(parameter int DATA_BITS = 8);
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..div while enabled, tick on the terminal count.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] r_cnt;

  assign tick = en && (r_cnt == div);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)      r_cnt <= '0;
    else if (!en)     r_cnt <= '0;
    else if (tick)    r_cnt <= '0;
    else              r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: push FIFO, baud divider and frame serialiser with CTS gating.
// Optional parity bit after the data field when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter  int DATA_BITS = 8,
  parameter  int DEPTH     = 16,
  parameter  int DIV_W     = 16,
  parameter  int LOW_WATER = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_stop2,
  input  logic             cfg_flow_en,
`ifdef UART_TX_PARITY_EN
  input  logic             cfg_par_odd,
`endif
  input  logic             clear,
  uart_tx_buffered_if.slave wr,
  input  logic             cts,
  output logic             tx,
  output logic             busy,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic             tx_low
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overrun;

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bitcnt;
  logic                 r_stop2, r_stop_hi;
  logic [DIV_W-1:0]     r_div;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  logic w_tick, w_push, w_pop, w_can_launch, w_last_stop;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign overrun = r_overrun;
  assign tx_low  = (r_count <= CW'(LOW_WATER));
  assign busy    = (r_state != IDLE);
  assign wr.wr_ready = !full;

  assign w_push       = wr.wr_valid && !full && !clear;
  assign w_can_launch = !empty && (cts || !cfg_flow_en);
  // The final stop tick may relaunch directly, giving back-to-back frames.
  assign w_last_stop  = (r_state == STOP) && w_tick && (!r_stop2 || r_stop_hi);
  assign w_pop        = w_can_launch && ((r_state == IDLE) || w_last_stop);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .nReset (nReset),
    .en     (busy),
    .div    (r_div),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr.wr_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (wr.wr_valid && full) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_stop2   <= 1'b0;
      r_stop_hi <= 1'b0;
      r_div     <= '0;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_pop) begin
      // Frame config is frozen here so mid-frame register writes take effect next frame.
      r_state   <= START;
      r_shift   <= r_mem[r_rptr];
      r_div     <= cfg_div;
      r_stop2   <= cfg_stop2;
      r_stop_hi <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par     <= (^r_mem[r_rptr]) ^ cfg_par_odd;
`endif
    end else if (w_tick) begin
      case (r_state)
        START: begin
          r_state  <= DATA;
          r_bitcnt <= '0;
        end
        DATA: begin
          r_shift <= r_shift >> 1;
          if (r_bitcnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            r_state <= PARITY;
`else
            r_state <= STOP;
`endif
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        PARITY: r_state <= STOP;
        STOP: begin
          if (r_stop2 && !r_stop_hi) r_stop_hi <= 1'b1;
          else                       r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:  tx = 1'b0;
      DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = r_par;
`endif
      default: tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboarded bench: stimulus queues expected frames, a line monitor decodes tx cycle by cycle.
module tb_uart_tx_buffered;
  localparam int DB = 8, DEPTH = 16, DIV_W = 16, LW = 2, CW = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0, nReset = 1'b0;
  always #5 clk = ~clk;

  logic [DIV_W-1:0] cfg_div;
  logic cfg_stop2, cfg_flow_en, clear, cts, par_odd;
  logic tx, busy, empty, full, overrun, tx_low;
  logic [CW-1:0] count;

  uart_tx_buffered_if #(.DATA_BITS(DB)) wr_if ();

  uart_tx_buffered #(.DATA_BITS(DB), .DEPTH(DEPTH), .DIV_W(DIV_W), .LOW_WATER(LW)) dut (
    .clk(clk), .nReset(nReset), .cfg_div(cfg_div), .cfg_stop2(cfg_stop2),
    .cfg_flow_en(cfg_flow_en),
`ifdef UART_TX_PARITY_EN
    .cfg_par_odd(par_odd),
`endif
    .clear(clear), .wr(wr_if), .cts(cts), .tx(tx), .busy(busy), .count(count),
    .empty(empty), .full(full), .overrun(overrun), .tx_low(tx_low));

  typedef struct {
    logic [DB-1:0] d;
    int            p;   // clocks per bit
    bit            s2;
    bit            pb;  // parity bit value
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference frame layout: start, data LSB first, optional parity, 1-2 stop bits.
  function automatic logic ebit(input exp_t e, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return e.d[i-1];
    if (PE && i == DB + 1) return e.pb;
    return 1'b1;
  endfunction

  function automatic int nbits(input exp_t e);
    return 1 + DB + int'(PE) + 1 + int'(e.s2);
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (nReset && tx === 1'b0) begin
        starts.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          for (int k = 0; k < 200 && tx === 1'b0; k++) @(negedge clk);
        end else begin
          exp_t e;
          bit   ok;
          e  = sb.pop_front();
          ok = 1'b1;
          for (int c = 1; c < nbits(e) * e.p; c++) begin
            @(negedge clk);
            if (tx !== ebit(e, c / e.p)) ok = 1'b0;
          end
          chk($sformatf("frame_%02h_p%0d", e.d, e.p), int'(ok), 1);
        end
      end
    end
  end

  task automatic push(input logic [DB-1:0] d, input bit acc);
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    if (acc) sb.push_back(exp_t'{d, int'(cfg_div) + 1, cfg_stop2,
                                 bit'($countones(d) % 2) ^ (PE & par_odd)});
    @(posedge clk);
    #1 wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_busy(input string nm, input bit lvl, input int max);
    int k = 0;
    @(negedge clk);
    while (busy !== lvl && k < max) begin @(negedge clk); k++; end
    if (k >= max) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic wait_drain(input string nm, input int max);
    int k = 0;
    @(negedge clk);
    while ((busy || !empty) && k < max) begin @(negedge clk); k++; end
    if (k >= max) chk({nm, "_drain_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    bit txok;
    cfg_div = 3; cfg_stop2 = 0; cfg_flow_en = 0; clear = 0; cts = 0; par_odd = 0;
    wr_if.wr_valid = 0; wr_if.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);       chk("rst_busy", busy, 0);
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);   chk("rst_overrun", overrun, 0);
    chk("rst_tx_low", tx_low, 1); chk("rst_wr_ready", wr_if.wr_ready, 1);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, div 3: one push, launch next cycle, 40-cycle frame
    push(8'hA5, 1'b1);
    @(negedge clk);
    chk("t1_count_after_push", count, 1); chk("t1_busy_pre", busy, 0); chk("t1_tx_pre", tx, 1);
    @(negedge clk);
    chk("t1_busy_launch", busy, 1); chk("t1_tx_start", tx, 0); chk("t1_count_popped", count, 0);
    k = 1;
    do begin @(negedge clk); if (busy) k++; end while (busy && k < 200);
    chk("t1_busy_len", k, 40);
    wait_drain("t1", 200);

    // Flow-controlled fill to overflow, then back-to-back drain
    cfg_flow_en = 1; cts = 0;
    for (int i = 0; i < 17; i++) begin
      int mc;
      push(8'($urandom), i < DEPTH);
      mc = (i < DEPTH) ? i + 1 : DEPTH;
      @(negedge clk);
      chk($sformatf("t2_count_%0d", i), count, mc);
      chk($sformatf("t2_tx_low_%0d", i), tx_low, int'(mc <= LW));
    end
    chk("t2_full", full, 1); chk("t2_wr_ready", wr_if.wr_ready, 0);
    chk("t2_overrun", overrun, 1); chk("t2_empty", empty, 0);
    txok = 1;
    repeat (20) begin @(negedge clk); if (tx !== 1'b1 || busy) txok = 0; end
    chk("t2_tx_held_idle", txok, 1);
    starts.delete();
    cts = 1;
    wait_drain("t2", 16 * 40 + 200);
    chk("t2_frames", starts.size(), 16);
    txok = 1;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 40) txok = 0;
    chk("t2_no_gaps", txok, 1);

    // CTS dropped mid-frame: frame completes, rest held
    push(8'h11, 1'b1); push(8'h22, 1'b1); push(8'h33, 1'b1);
    wait_busy("t3_start", 1'b1, 50);
    repeat (10) @(negedge clk);
    cts = 0;
    wait_busy("t3_end", 1'b0, 100);
    repeat (60) @(negedge clk);
    chk("t3_held_busy", busy, 0); chk("t3_held_count", count, 2); chk("t3_held_tx", tx, 1);
    cts = 1;
    wait_drain("t3", 300);

    // clear mid-frame with 5 queued
    for (int i = 0; i < 6; i++) push(8'($urandom), 1'b1);
    wait_busy("t4_start", 1'b1, 50);
    repeat (8) @(negedge clk);
    chk("t4_count_pre", count, 5); chk("t4_overrun_pre", overrun, 1);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (5) void'(sb.pop_back());
    @(negedge clk);
    chk("t4_count_clr", count, 0); chk("t4_overrun_clr", overrun, 0); chk("t4_empty_clr", empty, 1);
    chk("t4_frame_continues", busy, 1);
    wait_busy("t4_end", 1'b0, 100);
    repeat (60) @(negedge clk);
    chk("t4_no_more_busy", busy, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // Two stop bits, divisor change mid-frame applies to the next frame only
    cfg_stop2 = 1; cfg_div = 3;
    starts.delete();
    push(8'h5C, 1'b1);
    wait_busy("t5_start", 1'b1, 50);
    repeat (6) @(negedge clk);
    cfg_div = 7;
    push(8'hC3, 1'b1);
    wait_drain("t5", 400);
    chk("t5_frames", starts.size(), 2);
    if (starts.size() == 2) chk("t5_frame1_len", starts[1] - starts[0], 4 * nbits(exp_t'{8'h0, 4, 1'b1, 1'b0}));
    cfg_stop2 = 0; cfg_div = 3;

`ifdef UART_TX_PARITY_EN
    par_odd = 0; push(8'h07, 1'b1); wait_drain("t6_even", 200);
    par_odd = 1; push(8'h07, 1'b1); wait_drain("t6_odd", 200);
`endif

    // Randomised frames over divisor, stop bits and parity sense
    for (int it = 0; it < 24; it++) begin
      int n;
      cfg_div   = (it == 0) ? '0 : DIV_W'($urandom_range(0, 5));
      cfg_stop2 = 1'($urandom);
      par_odd   = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom), 1'b1);
      wait_drain($sformatf("rnd%0d", it), 600);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
